// File: rtl/timing_sequencer_pkg.sv
// Shared timing definitions for the control unit sequence counter.
// Used by the sequencer, its encoder and the time decoder.
package timing_sequencer_pkg;

    localparam int SC_W  = 4;
    localparam int T_NUM = 16;

    typedef logic [SC_W-1:0]  tcode_t;
    typedef logic [T_NUM-1:0] tvec_t;

    localparam tcode_t T0  = 4'd0;
    localparam tcode_t T1  = 4'd1;
    localparam tcode_t T2  = 4'd2;
    localparam tcode_t T3  = 4'd3;
    localparam tcode_t T4  = 4'd4;
    localparam tcode_t T5  = 4'd5;
    localparam tcode_t T6  = 4'd6;
    localparam tcode_t T7  = 4'd7;
    localparam tcode_t T8  = 4'd8;
    localparam tcode_t T9  = 4'd9;
    localparam tcode_t T10 = 4'd10;
    localparam tcode_t T11 = 4'd11;
    localparam tcode_t T12 = 4'd12;
    localparam tcode_t T13 = 4'd13;
    localparam tcode_t T14 = 4'd14;
    localparam tcode_t T15 = 4'd15;

    // Next timing state, rolling T15 over to T0.
    function automatic tcode_t tnext(input tcode_t c);
        return c + tcode_t'(1);
    endfunction

endpackage

// File: rtl/timing_sequencer_encoder.sv
// One-hot timing vector to 4-bit timing code (inverse of time decoder).
// valid is set only when exactly one bit of the vector is set.
module onehot_16_to_4_encoder
    import timing_sequencer_pkg::*;
(
    input  logic [T_NUM-1:0] onehot,
    output logic [SC_W-1:0]  code,
    output logic             valid
);

    logic seen;
    logic multi;

    // OR together indices of set bits and track whether more than one is set.
    always_comb begin
        code  = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < T_NUM; i++) begin
            if (onehot[i]) begin
                code = code | tcode_t'(i);
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
        valid = seen & ~multi;
    end

endmodule

// File: rtl/timing_sequencer.sv
// Sequence counter (SC) and start/stop flag (S) of the basic computer.
// Produces the registered timing code for the 4-to-16 time decoder.
module timing_sequencer
    import timing_sequencer_pkg::*;
#(
    parameter logic RESET_RUN = 1'b0
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hlt,
    input  logic             step,
    input  logic             clr,
    input  logic             ld,
    input  logic [T_NUM-1:0] ld_onehot,
    output logic [SC_W-1:0]  sc,
    output logic             running,
    output logic             wrap,
    output logic             enc_err
);

    tcode_t ld_code;
    logic   ld_code_ok;

    tcode_t sc_d;
    logic   s_d;
    logic   wrap_d;
    logic   enc_err_d;
    logic   ld_valid;
    logic   inc;

    onehot_16_to_4_encoder u_enc (
        .onehot (ld_onehot),
        .code   (ld_code),
        .valid  (ld_code_ok)
    );

    // Next SC by priority clr > valid ld > increment > hold; S by hlt > start.
    always_comb begin
        sc_d      = sc;
        s_d       = running;
        wrap_d    = 1'b0;
        ld_valid  = ld & ld_code_ok;
        enc_err_d = ld & ~ld_code_ok;
        inc       = running | step;

        if (clr) begin
            sc_d = T0;
        end else if (ld_valid) begin
            sc_d = ld_code;
        end else if (inc) begin
            sc_d   = tnext(sc);
            wrap_d = (sc == T15);
        end

        if (hlt) begin
            s_d = 1'b0;
        end else if (start) begin
            s_d = 1'b1;
        end
    end

    // State and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sc      <= T0;
            running <= RESET_RUN;
            wrap    <= 1'b0;
            enc_err <= 1'b0;
        end else begin
            sc      <= sc_d;
            running <= s_d;
            wrap    <= wrap_d;
            enc_err <= enc_err_d;
        end
    end

endmodule

// File: tb/tb_timing_sequencer.sv
// Self-checking bench for timing_sequencer.
// Directed scenarios followed by random traffic against a reference model.
module tb_timing_sequencer;

    localparam logic RST_RUN = 1'b0;

    logic        clk;
    logic        rst;
    logic        start;
    logic        hlt;
    logic        step;
    logic        clr;
    logic        ld;
    logic [15:0] ld_onehot;
    logic [3:0]  sc;
    logic        running;
    logic        wrap;
    logic        enc_err;

    int n_chk;
    int n_fail;

    int m_sc;
    int m_s;
    int m_wrap;
    int m_err;

    timing_sequencer #(.RESET_RUN(RST_RUN)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .hlt       (hlt),
        .step      (step),
        .clr       (clr),
        .ld        (ld),
        .ld_onehot (ld_onehot),
        .sc        (sc),
        .running   (running),
        .wrap      (wrap),
        .enc_err   (enc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 0; start = 0; hlt = 0; step = 0;
        clr = 0; ld = 0; ld_onehot = '0;
    endtask

    // Advance model one edge from the rules, then compare all outputs.
    task automatic tick(input string tag);
        int ones;
        int idx;
        int inc;
        @(posedge clk);
        if (rst) begin
            m_sc = 0; m_s = RST_RUN; m_wrap = 0; m_err = 0;
        end else begin
            ones = 0;
            idx  = 0;
            for (int k = 0; k < 16; k++) begin
                if (ld_onehot[k]) begin
                    ones++;
                    idx = k;
                end
            end
            inc    = m_s | step;
            m_err  = (ld && ones != 1) ? 1 : 0;
            m_wrap = 0;
            if (clr) begin
                m_sc = 0;
            end else if (ld && ones == 1) begin
                m_sc = idx;
            end else if (inc != 0) begin
                m_wrap = (m_sc == 15) ? 1 : 0;
                m_sc   = (m_sc + 1) % 16;
            end
            if (hlt) m_s = 0;
            else if (start) m_s = 1;
        end
        #1;
        chk({tag, ".sc"}, int'(sc), m_sc);
        chk({tag, ".run"}, int'(running), m_s);
        chk({tag, ".wrap"}, int'(wrap), m_wrap);
        chk({tag, ".err"}, int'(enc_err), m_err);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        m_sc = 0; m_s = 0; m_wrap = 0; m_err = 0;
        idle();
        rst = 1;
        tick("rst");
        chk("rst_sc", int'(sc), 0);
        chk("rst_run", int'(running), int'(RST_RUN));

        idle(); start = 1;
        tick("start");
        chk("start_hold", int'(sc), 0);
        idle();
        for (int i = 1; i <= 16; i++) begin
            tick("count");
            chk("count_sc", int'(sc), i % 16);
            chk("count_wrap", int'(wrap), (i == 16) ? 1 : 0);
        end

        for (int i = 0; i < 5; i++) tick("to5");
        chk("at5", int'(sc), 5);
        clr = 1; ld = 1; ld_onehot = 16'h0100;
        tick("clr_ld");
        chk("clr_ld_sc", int'(sc), 0);
        chk("clr_ld_err", int'(enc_err), 0);

        idle(); hlt = 1;
        tick("hlt");
        idle(); ld = 1; ld_onehot = 16'h0008;
        tick("ld3");
        chk("ld3_sc", int'(sc), 3);
        ld_onehot = 16'h0080;
        tick("ld7");
        chk("ld7_sc", int'(sc), 7);
        idle();
        for (int i = 8; i <= 10; i++) begin
            step = 1;
            tick("step");
            chk("step_sc", int'(sc), i);
            step = 0;
            tick("nostep");
            chk("nostep_sc", int'(sc), i);
        end

        start = 1;
        tick("restart");
        idle(); ld = 1; ld_onehot = 16'h0004;
        tick("ld2");
        chk("ld2_sc", int'(sc), 2);
        ld_onehot = 16'h0000;
        tick("ld_zero");
        chk("ldz_sc", int'(sc), 3);
        chk("ldz_err", int'(enc_err), 1);
        idle();
        tick("after_z");
        chk("after_z_err", int'(enc_err), 0);
        ld = 1; ld_onehot = 16'h0011;
        tick("ld_multi");
        chk("ldm_sc", int'(sc), 5);
        chk("ldm_err", int'(enc_err), 1);
        ld = 1; ld_onehot = 16'h0000; clr = 1;
        tick("clr_bad");
        chk("clr_bad_sc", int'(sc), 0);
        chk("clr_bad_err", int'(enc_err), 1);

        idle(); ld = 1; ld_onehot = 16'h0040;
        tick("ld6");
        idle(); start = 1; hlt = 1;
        tick("sthlt");
        chk("sthlt_sc", int'(sc), 7);
        chk("sthlt_run", int'(running), 0);
        idle();
        tick("halted");
        chk("halted_sc", int'(sc), 7);

        start = 1;
        tick("go");
        idle(); ld = 1; ld_onehot = 16'h0200;
        tick("ld9");
        chk("ld9_sc", int'(sc), 9);
        ld_onehot = 16'h8000; rst = 1;
        tick("rst_ld");
        chk("rst_ld_sc", int'(sc), 0);
        chk("rst_ld_run", int'(running), int'(RST_RUN));

        for (int i = 0; i < 3000; i++) begin
            idle();
            rst   = ($urandom_range(0, 99) == 0);
            start = ($urandom_range(0, 15) == 0);
            hlt   = ($urandom_range(0, 15) == 0);
            step  = ($urandom_range(0, 3) == 0);
            clr   = ($urandom_range(0, 19) == 0);
            ld    = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0: ld_onehot = 16'($urandom);
                1: ld_onehot = '0;
                default: ld_onehot = 16'(1) << $urandom_range(0, 15);
            endcase
            tick("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/timing_sequencer.md
# timing_sequencer

Generates the 4-bit timing code that feeds the 4-to-16 time decoder of the basic computer control unit. It contains the sequence counter (SC) and the start/stop flag (S). It also provides the reverse path: a 16-bit one-hot timing vector is encoded back to a 4-bit code and loaded into SC. While S is set, SC advances one state per clock (T0, T1, …, T15). Control logic can clear it, jump it, halt it or single-step it.

## Interface
Parameters:
- RESET_RUN, default 1'b0: value of S after reset (0 = stopped).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  sets S (run).
- hlt  in  1  clears S (HLT instruction).
- step  in  1  while S=0, advances SC by one; ignored while S=1.
- clr  in  1  SC ← 0 (end of instruction / interrupt entry).
- ld  in  1  load SC from the encoded one-hot vector.
- ld_onehot  in  16  one-hot timing vector; bit k selects Tk.
- sc  out  4  current timing code; drives the time decoder.
- running  out  1  S flag.
- wrap  out  1  one-cycle pulse when an increment takes SC from 15 to 0.
- enc_err  out  1  one-cycle pulse when ld is asserted with ld_onehot not exactly one-hot.

## Operation
- Reset values: sc=0, running=RESET_RUN, wrap=0, enc_err=0.
- SC update priority, evaluated each edge: rst > clr > ld (valid) > increment > hold.
  - Increment condition: (S=1) or (S=0 and step=1).
- clr forces SC to 0 regardless of ld, step or S. A clr does not assert wrap.
- Valid ld sets SC to the index of the single set bit of ld_onehot.
- Invalid ld (zero bits or more than one bit set):
  - No load occurs.
  - enc_err pulses on the next cycle.
  - The SC update falls through to increment/hold as if ld=0.
  - If clr is also asserted, clr still applies, and enc_err still pulses.
- S flag update:
  - hlt=1 → S ← 0.
  - else start=1 → S ← 1.
  - else S holds.
  - hlt wins when start and hlt are asserted together.
- S changes take effect on the increment decision of the following cycle. On the edge where hlt is sampled, the increment still uses the old S.
- wrap asserts only for the increment path 15→0. It does not assert for a clr, or for an ld of T0.
- step while S=1 has no additional effect. There is never a double increment.

## Timing
- All outputs are registered. Every input affects the outputs exactly one clock later.
- The decoder sees the new sc one cycle after clr or ld. For example, clr at cycle n gives T0 in cycle n+1.
- There is no combinational path from any input to any output.
- rst mid-operation: on the next edge all state returns to its reset values. Pending ld, clr and step are discarded.
- Continuous run from sc=0 gives sc 0,1,…,15,0. wrap is high in the cycle where sc=0 after 15.

## Structure
- Shared package:
  - SC_W = 4 and T_NUM = 16.
  - Named constants T0..T15, shared with the time decoder.
- Sub-module onehot_16_to_4_encoder (combinational):
  - Input: 16-bit vector.
  - Outputs: 4-bit code and a valid flag. valid = exactly one bit set.
  - This is the inverse of the time decoder.
- The top level holds the SC register, the S flip-flop, and the wrap/enc_err pulse registers.

## Test plan
- Reset with RESET_RUN=0, then start for one cycle → sc holds 0 during start cycle, then counts 1,2,…,15,0. wrap is high exactly in the sc=0 cycle after 15.
- Running at sc=5, assert clr and ld with ld_onehot=16'h0100 in the same cycle → next sc=0, enc_err=0.
- Stopped at sc=3, pulse ld with ld_onehot=16'h0080 → sc=7. Then step three single cycles → sc=8,9,10. Holding step low → sc stays 10.
- Running at sc=2, ld with 16'h0000 → sc=3 and enc_err pulses once. Repeat with 16'h0011 → same behaviour.
- Running at sc=6, start and hlt asserted together → sc=7 on that edge, running=0 afterwards, sc holds at 7.
- Running at sc=9, assert rst together with ld of 16'h8000 → sc=0, running=RESET_RUN, wrap=0, enc_err=0.
